// File: rtl/funct_generator_pkg.sv
// Shared types and helpers for the function generator register bank.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package funct_generator_pkg;

  // Default geometry of the bank.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_CH     = 4;

  // Widest register the parity helper accepts; narrower values are zero-extended,
  // which leaves the parity unchanged.
  localparam int PAR_MAX_W      = 64;

  // Commit controller states.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_e;

  // Even-parity bit: makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/funct_generator_reg_bank_fsm.sv
// Commit controller: arms on commit_req, fires a transfer strobe on the next frame_sync.
// Latency: transfer strobe is combinational in the frame_sync cycle; commit_done follows one cycle later.
// Backpressure: none; commit_req while PENDING is dropped, clrh aborts a pending commit.
module funct_generator_reg_bank_fsm
  import funct_generator_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clrh_i,
  input  logic commit_req_i,
  input  logic frame_sync_i,
  output logic busy_o,
  output logic commit_done_o,
  output logic transfer_o
);

  commit_state_e state_q, state_d;
  logic          commit_done_q, commit_done_d;
  logic          transfer;

  // State and completion pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_done_q <= commit_done_d;
    end
  end

  // Next-state decode; a frame_sync in the arming cycle is deliberately not a transfer.
  always_comb begin
    state_d       = state_q;
    commit_done_d = 1'b0;
    transfer      = 1'b0;
    if (clrh_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (commit_req_i) begin
            state_d = PENDING;
          end
        end
        PENDING: begin
          if (frame_sync_i) begin
            transfer      = 1'b1;
            commit_done_d = 1'b1;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q == PENDING);
  assign commit_done_o = commit_done_q;
  assign transfer_o    = transfer;

endmodule

// File: rtl/funct_generator_reg_bank.sv
// Double-buffered channel register bank: writes land in shadows, dirty shadows move to active on a committed frame_sync.
// Latency: readback 1 cycle; active (q) updates on the frame_sync edge after commit_req; optional parity via FUNCT_GEN_REG_PARITY_EN.
// Backpressure: none; out-of-range writes are dropped and flagged on wr_err, busy shows a pending commit.
module funct_generator_reg_bank
  import funct_generator_pkg::*;
#(
  parameter int                        DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                        NUM_CH      = DEF_NUM_CH,
  parameter logic [DATA_WIDTH-1:0]     RESET_VALUE = '0,
  localparam int                       ADDR_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clrh,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_err,
  input  logic                         commit_req,
  input  logic                         frame_sync,
  output logic                         busy,
  output logic                         commit_done,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
`ifdef FUNCT_GEN_REG_PARITY_EN
  output logic                         par_err,
`endif
  output logic [NUM_CH*DATA_WIDTH-1:0] q
);

  // One extra bit so that NUM_CH itself is representable for the range check.
  localparam logic [ADDR_W:0] NUM_CH_C = (ADDR_W+1)'(NUM_CH);

  logic [DATA_WIDTH-1:0] shadow_q [NUM_CH];
  logic [DATA_WIDTH-1:0] shadow_d [NUM_CH];
  logic [DATA_WIDTH-1:0] active_q [NUM_CH];
  logic [DATA_WIDTH-1:0] active_d [NUM_CH];
  logic [NUM_CH-1:0]     dirty_q, dirty_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_err_q, wr_err_d;
  logic [NUM_CH-1:0]     wr_hit;
  logic                  wr_oob;
  logic                  transfer;

  funct_generator_reg_bank_fsm u_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .clrh_i        (clrh),
    .commit_req_i  (commit_req),
    .frame_sync_i  (frame_sync),
    .busy_o        (busy),
    .commit_done_o (commit_done),
    .transfer_o    (transfer)
  );

  // Per-channel write decode and out-of-range detection.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_en && (wr_addr == ADDR_W'(i));
    end
    wr_oob = wr_en && ({1'b0, wr_addr} >= NUM_CH_C);
  end

  // Bank next state: clrh wins; a transfer copies pre-write shadows, and a same-cycle write re-dirties its channel.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    dirty_d   = dirty_q;
    rd_data_d = '0;
    wr_err_d  = 1'b0;
    if (clrh) begin
      shadow_d = '{default: '0};
      active_d = '{default: '0};
      dirty_d  = '0;
    end else begin
      if (transfer) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (dirty_q[i]) begin
            active_d[i] = shadow_q[i];
          end
        end
        dirty_d = '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) begin
          shadow_d[i] = wr_data;
          dirty_d[i]  = 1'b1;
        end
      end
      // Readback sees the shadow before any same-cycle write; unmatched addresses read 0.
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_addr == ADDR_W'(i)) begin
          rd_data_d = shadow_q[i];
        end
      end
      wr_err_d = wr_oob;
    end
  end

  // Bank storage, dirty mask and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '{default: RESET_VALUE};
      active_q  <= '{default: RESET_VALUE};
      dirty_q   <= '0;
      rd_data_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      dirty_q   <= dirty_d;
      rd_data_q <= rd_data_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign rd_data = rd_data_q;
  assign wr_err  = wr_err_q;

  // Active registers go straight out, channel 0 in the LSBs.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_q
    assign q[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
  end

`ifdef FUNCT_GEN_REG_PARITY_EN
  logic [NUM_CH-1:0] par_q, par_d, par_mis;
  logic              par_err_q, par_err_d;

  // Parity is captured from the shadow alongside the data; any active mismatch latches par_err.
  always_comb begin
    par_d     = par_q;
    par_mis   = '0;
    par_err_d = par_err_q;
    for (int i = 0; i < NUM_CH; i++) begin
      par_mis[i] = (even_parity(PAR_MAX_W'(active_q[i])) != par_q[i]);
    end
    if (clrh) begin
      par_d     = '0;
      par_err_d = 1'b0;
    end else begin
      if (transfer) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (dirty_q[i]) begin
            par_d[i] = even_parity(PAR_MAX_W'(shadow_q[i]));
          end
        end
      end
      par_err_d = par_err_q | (|par_mis);
    end
  end

  // Parity storage and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q     <= {NUM_CH{even_parity(PAR_MAX_W'(RESET_VALUE))}};
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_funct_generator_reg_bank.sv
// Self-checking bench for funct_generator_reg_bank (NUM_CH=6, DATA_WIDTH=8, RESET_VALUE=8'h5A).
// Inputs change 1ns after the rising edge; outputs are compared 1ns after the edge that produces them.
// Readback expectations go through a queue: pushed with the stimulus, popped when rd_data is produced.
module tb_funct_generator_reg_bank;

  localparam int             DW  = 8;
  localparam int             NCH = 6;
  localparam int             AW  = 3;
  localparam logic [DW-1:0]  RV  = 8'h5A;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clrh;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_err;
  logic              commit_req;
  logic              frame_sync;
  logic              busy;
  logic              commit_done;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic [NCH*DW-1:0] q;
`ifdef FUNCT_GEN_REG_PARITY_EN
  logic              par_err;
`endif

  funct_generator_reg_bank #(
    .DATA_WIDTH  (DW),
    .NUM_CH      (NCH),
    .RESET_VALUE (RV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clrh        (clrh),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .commit_req  (commit_req),
    .frame_sync  (frame_sync),
    .busy        (busy),
    .commit_done (commit_done),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
`ifdef FUNCT_GEN_REG_PARITY_EN
    .par_err     (par_err),
`endif
    .q           (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
  } vec_t;

  vec_t              vecs [8];
  logic [DW-1:0]     exp_rd_q [$];
  logic [NCH*DW-1:0] exp_q;
  int                n_checks = 0;
  int                n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input string name);
    rd_addr = a;
    exp_rd_q.push_back(e);
    step();
    check(name, rd_data, exp_rd_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clrh = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; commit_req = 1'b0; frame_sync = 1'b0;
    exp_q = {NCH{RV}};

    // Writes and readback; expected rd_data is the shadow before that cycle's write.
    vecs[0] = '{1'b1, 3'd1, 8'hA5, 3'd1, 8'h5A, 1'b0};
    vecs[1] = '{1'b1, 3'd3, 8'h3C, 3'd1, 8'hA5, 1'b0};
    vecs[2] = '{1'b1, 3'd6, 8'hFF, 3'd3, 8'h3C, 1'b1};
    vecs[3] = '{1'b0, 3'd0, 8'h00, 3'd6, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 3'd7, 8'hEE, 3'd0, 8'h5A, 1'b1};
    vecs[5] = '{1'b0, 3'd0, 8'h00, 3'd7, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 3'd0, 8'h00, 3'd5, 8'h5A, 1'b0};
    vecs[7] = '{1'b0, 3'd0, 8'h00, 3'd2, 8'h5A, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", q, exp_q);
    check("rst_busy", busy, 1'b0);
    check("rst_rd", rd_data, 8'h00);
    check("rst_done", commit_done, 1'b0);
    check("rst_err", wr_err, 1'b0);
    rst_n = 1'b1;
    step();
    check("rel_q", q, exp_q);
    check("rel_busy", busy, 1'b0);

    // Table-driven writes / readback / out-of-range
    for (int i = 0; i < 8; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr;
      wr_data = vecs[i].wr_data;
      rd_addr = vecs[i].rd_addr;
      exp_rd_q.push_back(vecs[i].exp_rd);
      step();
      check($sformatf("vec%0d_rd", i), rd_data, exp_rd_q.pop_front());
      check($sformatf("vec%0d_err", i), wr_err, vecs[i].exp_err);
      check($sformatf("vec%0d_q", i), q, exp_q);
    end
    wr_en = 1'b0;

    // frame_sync while IDLE does nothing
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    check("idle_fs_q", q, exp_q);
    check("idle_fs_busy", busy, 1'b0);
    check("idle_fs_done", commit_done, 1'b0);

    // Commit, frame_sync five cycles later
    commit_req = 1'b1; step(); commit_req = 1'b0;
    check("pend_busy", busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("pend_q%0d", k), q, exp_q);
    end
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    exp_q[8 +: 8]  = 8'hA5;
    exp_q[24 +: 8] = 8'h3C;
    check("xfer_q", q, exp_q);
    check("xfer_done", commit_done, 1'b1);
    check("xfer_busy", busy, 1'b0);
    step();
    check("done_pulse", commit_done, 1'b0);
    check("post_q", q, exp_q);

    // commit_req and frame_sync together: arm only
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h77; step(); wr_en = 1'b0;
    commit_req = 1'b1; frame_sync = 1'b1; step(); commit_req = 1'b0; frame_sync = 1'b0;
    check("same_busy", busy, 1'b1);
    check("same_q", q, exp_q);
    check("same_done", commit_done, 1'b0);
    step();
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    exp_q[0 +: 8] = 8'h77;
    check("same_xfer_q", q, exp_q);
    check("same_xfer_done", commit_done, 1'b1);

    // Write landing in the transfer cycle
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h22; step(); wr_en = 1'b0;
    commit_req = 1'b1; step(); commit_req = 1'b0;
    frame_sync = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
    step();
    frame_sync = 1'b0; wr_en = 1'b0;
    exp_q[16 +: 8] = 8'h22;
    check("wdt_q", q, exp_q);
    check("wdt_done", commit_done, 1'b1);
    step_rd(3'd2, 8'h11, "wdt_shadow");
    commit_req = 1'b1; step(); commit_req = 1'b0;
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    exp_q[16 +: 8] = 8'h11;
    check("wdt_next_q", q, exp_q);

    // Empty commit
    commit_req = 1'b1; step(); commit_req = 1'b0;
    check("empty_busy", busy, 1'b1);
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    check("empty_q", q, exp_q);
    check("empty_done", commit_done, 1'b1);
    check("empty_busy_lo", busy, 1'b0);

    // clrh while PENDING with dirty data (plus an out-of-range write that must not flag)
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h99; step(); wr_en = 1'b0;
    commit_req = 1'b1; step(); commit_req = 1'b0;
    check("clr_pre_busy", busy, 1'b1);
    clrh = 1'b1; wr_en = 1'b1; wr_addr = 3'd6; rd_addr = 3'd1;
    step();
    clrh = 1'b0; wr_en = 1'b0;
    exp_q = '0;
    check("clr_q", q, exp_q);
    check("clr_busy", busy, 1'b0);
    check("clr_rd", rd_data, 8'h00);
    check("clr_done", commit_done, 1'b0);
    check("clr_err", wr_err, 1'b0);
    step_rd(3'd4, 8'h00, "clr_sh4");
    step_rd(3'd1, 8'h00, "clr_sh1");
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    check("clr_fs_q", q, exp_q);
    check("clr_fs_done", commit_done, 1'b0);
    check("clr_fs_busy", busy, 1'b0);

    // Fresh commit after clear, then asynchronous reset mid-cycle
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h44; step(); wr_en = 1'b0;
    commit_req = 1'b1; step(); commit_req = 1'b0;
    frame_sync = 1'b1; step(); frame_sync = 1'b0;
    exp_q[40 +: 8] = 8'h44;
    check("post_clr_q", q, exp_q);
`ifdef FUNCT_GEN_REG_PARITY_EN
    check("par_err", par_err, 1'b0);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", q, {NCH{RV}});
    check("arst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step_rd(3'd5, RV, "arst_shadow");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/funct_generator_reg_bank.md
Name: funct_generator_reg_bank

Overview:
- Parametrised, double-buffered multi-channel register bank for the function generator datapath.
- Software/controller writes land in per-channel shadow registers.
- Active registers that drive the generator are updated atomically on a frame boundary, after a commit request.
- Replaces single-register instances where several channel settings must change together, with no glitch.

Parameters:
- DATA_WIDTH, 8, width of each channel register.
- NUM_CH, 4, number of channels (>=2).
- RESET_VALUE, 0, value loaded into shadow and active registers on reset.
- ADDR_W (localparam), $clog2(NUM_CH), channel address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clrh  in  1  synchronous clear of the whole bank, active-high.
- wr_en  in  1  shadow write strobe.
- wr_addr  in  ADDR_W  shadow channel index for the write.
- wr_data  in  DATA_WIDTH  write data.
- wr_err  out  1  one-cycle pulse flagging an out-of-range write address.
- commit_req  in  1  request to transfer dirty shadows to active (pulse).
- frame_sync  in  1  frame-boundary strobe from the generator timebase.
- busy  out  1  high while a commit is pending.
- commit_done  out  1  one-cycle pulse after the transfer.
- rd_addr  in  ADDR_W  shadow readback index.
- rd_data  out  DATA_WIDTH  registered shadow readback.
- q  out  NUM_CH*DATA_WIDTH  active registers, channel 0 in the LSBs.

Behaviour:
- Reset (rst_n=0, async):
  - All shadow and active registers = RESET_VALUE.
  - dirty mask = 0, state = IDLE.
  - wr_err = 0, commit_done = 0, rd_data = 0.
- clrh (sync) has priority over all other activity in that cycle:
  - Shadow, active, dirty and rd_data are cleared to 0 (not RESET_VALUE).
  - State returns to IDLE; wr_err and commit_done stay 0 that cycle.
- Write: on wr_en with wr_addr<NUM_CH, shadow[wr_addr]<=wr_data and dirty[wr_addr]<=1.
- Out-of-range write (wr_addr>=NUM_CH): ignored; wr_err=1 on the next cycle for one cycle.
- State machine with two states, IDLE and PENDING:
  - IDLE: commit_req -> PENDING. frame_sync alone has no effect.
  - PENDING: commit_req is ignored. frame_sync -> transfer, then IDLE.
  - Transfer: for every i with dirty[i]=1, active[i]<=shadow[i]; dirty is cleared; commit_done=1 in the following cycle.
- busy = (state==PENDING), registered state decode.
- commit_req and frame_sync in the same IDLE cycle: enter PENDING only. The transfer waits for the next frame_sync; there is no same-cycle shortcut.
- Write during the transfer cycle:
  - Active takes the pre-write shadow value.
  - The written shadow holds the new value and its dirty bit stays set for the next commit.
- Non-dirty channels keep their active value through a commit.
- An empty commit (no dirty bits) still completes: busy, then commit_done, with no change to q.
- Readback: rd_data<=shadow[rd_addr], 1-cycle latency. Out-of-range rd_addr returns 0.
- A same-cycle write to rd_addr returns the old shadow value.
- q is driven straight from the active flops; it changes only on a transfer, clrh or reset.

Optional Feature:
- Macro: FUNCT_GEN_REG_PARITY_EN.
- With the macro:
  - Each active register carries an even-parity bit, computed from the shadow at transfer.
  - Added output par_err (1 bit, registered) goes high the cycle after any active parity mismatch.
  - par_err is sticky until clrh or reset.
- Without the macro: no parity storage and no par_err port.

Decomposition:
- Package funct_generator_pkg holds:
  - state enum typedef (IDLE, PENDING);
  - default DATA_WIDTH/NUM_CH constants;
  - a parity function.
- Natural sub-module: funct_generator_reg_bank_fsm (commit controller: state, busy, commit_done, transfer strobe).
- Register storage is generated inline.

Test Plan:
- Reset then release -> q = {NUM_CH{RESET_VALUE}}, busy=0, rd_data=0.
- Write ch1=8'hA5, ch3=8'h3C; commit_req; frame_sync 5 cycles later -> q unchanged until the frame_sync edge; then ch1=A5, ch3=3C, others unchanged; commit_done one pulse; busy low.
- commit_req and frame_sync in the same cycle -> busy=1, no transfer. Next frame_sync transfers.
- Write ch2=8'h11 in the frame_sync transfer cycle with ch2 already dirty at 8'h22 -> active ch2=22, shadow ch2=11 and still dirty. The next commit yields 11.
- wr_addr=NUM_CH (out of range) with NUM_CH=6 -> no register change; wr_err pulses once. rd_addr=6 -> rd_data=0.
- clrh asserted while PENDING with dirty data -> q=0, shadows=0, busy=0. A later frame_sync causes no transfer.
